// File: rtl/ps2_keyboard_rx_if.sv
// Consumer-side bundle of the PS/2 receiver: decoded code, handshake and status pulses.
// valid/ready: a code transfers on any cycle where valid && ready are both high; while
// valid && !ready the fields hold stable, and valid never waits on ready to rise.
interface ps2_keyboard_rx_if;
    logic [7:0] data;
    logic       is_break;
    logic       is_extended;
    logic       valid;
    logic       ready;
    logic       frame_error;
    logic       overrun;
    logic [1:0] dbg_state;

    modport master (
        output data, is_break, is_extended, valid, frame_error, overrun, dbg_state,
        input  ready
    );

    modport slave (
        input  data, is_break, is_extended, valid, frame_error, overrun, dbg_state,
        output ready
    );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises and deglitches the keyboard clock, shifts in
// 11-bit frames, folds the E0/F0 prefixes into flags and presents one code at a time.
module ps2_keyboard_rx #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 16000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    ps2_keyboard_rx_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam int FW = $clog2(FILTER + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER - 1);
    localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT);

    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic [FW-1:0] r_filt_cnt;
    logic          r_filt_clk;
    state_t        r_state;
    logic [3:0]    r_bit_cnt;
    logic [9:0]    r_shift;
    logic [TW-1:0] r_to_cnt;
    logic          r_pend_brk, r_pend_ext;
    logic [7:0]    r_data;
    logic          r_brk, r_ext, r_valid, r_ferr, r_ovr;

    logic          w_fall, w_good;
    logic [7:0]    w_byte;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // The filtered level flips on the FILTER-th consecutive sample that disagrees with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_filt_cnt <= '0;
            r_filt_clk <= 1'b1;
        end else if (r_clk_s2 == r_filt_clk) begin
            r_filt_cnt <= '0;
        end else if (r_filt_cnt == FILT_LAST) begin
            r_filt_clk <= r_clk_s2;
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
        end
    end

    assign w_fall = r_filt_clk && !r_clk_s2 && (r_filt_cnt == FILT_LAST);
    // r_shift after a full frame: [7:0] data, [8] parity, [9] stop.
    assign w_good = (^r_shift[8:0]) && r_shift[9];
    assign w_byte = r_shift[7:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_to_cnt   <= '0;
            r_pend_brk <= 1'b0;
            r_pend_ext <= 1'b0;
            r_data     <= 8'h00;
            r_brk      <= 1'b0;
            r_ext      <= 1'b0;
            r_valid    <= 1'b0;
            r_ferr     <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
            if (w_fall) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != TO_MAX) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (r_valid && bus.ready) begin
                r_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_fall && !r_dat_s2) begin
                        r_state   <= SHIFT;
                        r_bit_cnt <= 4'd1;
                    end
                end
                SHIFT: begin
                    if (w_fall) begin
                        r_shift   <= {r_dat_s2, r_shift[9:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 4'd10) begin
                            r_state <= CHECK;
                        end
                    end else if (r_to_cnt == TO_MAX) begin
                        r_state    <= IDLE;
                        r_bit_cnt  <= '0;
                        r_ferr     <= 1'b1;
                        r_pend_brk <= 1'b0;
                        r_pend_ext <= 1'b0;
                    end
                end
                CHECK: begin
                    r_state   <= IDLE;
                    r_bit_cnt <= '0;
                    if (!w_good) begin
                        r_ferr     <= 1'b1;
                        r_pend_brk <= 1'b0;
                        r_pend_ext <= 1'b0;
                    end else if (w_byte == 8'hE0) begin
                        r_pend_ext <= 1'b1;
                    end else if (w_byte == 8'hF0) begin
                        r_pend_brk <= 1'b1;
                    end else begin
                        r_pend_brk <= 1'b0;
                        r_pend_ext <= 1'b0;
                        // A code landing on an accepting cycle replaces the old one seamlessly.
                        if (r_valid && !bus.ready) begin
                            r_ovr <= 1'b1;
                        end else begin
                            r_data  <= w_byte;
                            r_brk   <= r_pend_brk;
                            r_ext   <= r_pend_ext;
                            r_valid <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.data        = r_data;
    assign bus.is_break    = r_brk;
    assign bus.is_extended = r_ext;
    assign bus.valid       = r_valid;
    assign bus.frame_error = r_ferr;
    assign bus.overrun     = r_ovr;
    assign bus.dbg_state   = r_state;
endmodule

// File: doc/ps2_keyboard_rx.md
PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 SHALL have parameter FILTER, default 8: consecutive identical ps2_clk samples required before the filtered level changes.
REQ-002 SHALL have parameter TIMEOUT, default 16000: clk cycles without a ps2_clk falling edge mid-frame before the frame is aborted.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ps2_clk  input  1  raw keyboard clock, asynchronous.
REQ-006 SHALL have port ps2_data  input  1  raw keyboard data, asynchronous.
REQ-007 SHALL have port data  output  8  received scancode (prefixes stripped).
REQ-008 SHALL have port is_break  output  1  code was preceded by 0xF0.
REQ-009 SHALL have port is_extended  output  1  code was preceded by 0xE0.
REQ-010 SHALL have port valid  output  1  data/is_break/is_extended hold a code.
REQ-011 SHALL have port ready  input  1  consumer accepts the code when valid && ready.
REQ-012 SHALL have port frame_error  output  1  one-cycle pulse on a bad start, parity, stop or timeout.
REQ-013 SHALL have port overrun  output  1  one-cycle pulse when a completed code is dropped.

Function
REQ-014 SHALL pass ps2_clk and ps2_data through 2-flop synchronisers before any use.
REQ-015 SHALL change the filtered clock only after FILTER consecutive equal synchronised samples; a falling edge is a filtered 1->0 transition, one cycle wide.
REQ-016 SHALL sample synchronised ps2_data on each falling edge; frame = start(0), 8 data bits LSB first, odd parity, stop(1).
REQ-017 SHALL use states IDLE, SHIFT, CHECK: IDLE->SHIFT on a falling edge with data 0; falling edge with data 1 in IDLE is ignored; SHIFT->CHECK on the 11th sampled bit; CHECK->IDLE after one cycle.
REQ-018 In CHECK, a frame SHALL be good only if the parity bit makes the 9-bit count of ones odd and the stop bit is 1; otherwise frame_error pulses, the byte is discarded and both prefix flags clear.
REQ-019 SHALL keep a timeout counter that clears on every falling edge; on reaching TIMEOUT in SHIFT it SHALL return to IDLE, discard the partial frame, pulse frame_error and clear the prefix flags.
REQ-020 A good byte 0xE0 SHALL set the pending-extended flag; 0xF0 SHALL set the pending-break flag; neither is presented on data.
REQ-021 Any other good byte SHALL load data, is_break and is_extended from the byte and pending flags, set valid the cycle after CHECK, and clear both pending flags.
REQ-022 Output fields SHALL hold stable while valid && !ready; valid clears on the cycle after valid && ready.
REQ-023 If a code completes while valid && !ready, it SHALL be dropped, overrun pulses, held output unchanged, pending flags cleared.
REQ-024 If a code completes in the same cycle as valid && ready, the new code SHALL load and valid remain 1, no overrun.
REQ-025 Latency: valid SHALL rise exactly 2 cycles after the falling edge that samples the stop bit.
REQ-026 Timeout counter SHALL saturate, never wrap.

Reset
REQ-027 On reset, state SHALL be IDLE, bit counter, timeout counter, filter counter and pending flags 0, filtered clock 1.
REQ-028 On reset, data=0x00, is_break=0, is_extended=0, valid=0, frame_error=0, overrun=0.
REQ-029 Reset mid-frame SHALL discard the partial frame; the next frame with start bit 0 is received normally.

Verification
REQ-030 Frame 0x1C, parity 0, stop 1, ready=1 -> valid for one cycle with data=0x1C, is_break=0, is_extended=0.
REQ-031 Frames 0xE0, 0xF0, 0x75 -> one valid: data=0x75, is_break=1, is_extended=1; preceding prefixes produce no valid.
REQ-032 Frame 0x1C with parity 1 -> frame_error pulse, no valid; following clean 0x29 (parity 0) -> data=0x29, flags 0.
REQ-033 Start + 5 bits then idle clock high for TIMEOUT cycles -> frame_error pulse, state IDLE; clean 0x29 next -> data=0x29.
REQ-034 ready=0, frames 0x1C then 0x32 -> data stays 0x1C, overrun pulses once; ready=1 -> valid drops next cycle.
REQ-035 Reset asserted after 4 bits of a frame, then clean 0x1C -> data=0x1C, no frame_error.
